// File: rtl/low_freq_generator.sv
// ============================================================================
//  Module      : low_freq_generator
//  Description : Square-wave generator driven by a 4-digit BCD frequency in Hz;
//                half-period = (CLK_HZ/2) / freq, found by restoring division.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module low_freq_generator #(
    parameter int CLK_HZ = 100_000_000,
    parameter int W      = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] bcd3,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd0,
    output logic       sq_out,
    output logic       ready,
    output logic       done_tick,
    output logic       err
);

    localparam logic [W-1:0] c_DIVIDEND = W'(CLK_HZ / 2);
    localparam int           c_CW       = $clog2(W);
    localparam logic [c_CW-1:0] c_DIV_LAST = c_CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DIV  = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [15:0]     r_bcd;
    logic            r_bad;
    logic [1:0]      r_idx;
    logic [13:0]     r_acc;
    logic [W-1:0]    r_rem;
    logic [W-1:0]    r_quo;
    logic [c_CW-1:0] r_dcnt;
    logic [W-1:0]    r_half;
    logic [W-1:0]    r_cnt;
    logic            r_sq;
    logic            r_done;
    logic            r_err;

    logic            w_accept;
    logic            w_in_bad;
    logic [3:0]      w_digit;
    logic [13:0]     w_acc_next;
    logic            w_conv_last;
    logic            w_conv_bad;
    logic [W-1:0]    w_divisor;
    logic [W:0]      w_shift;
    logic            w_ge;
    logic [W-1:0]    w_rem_next;
    logic [W-1:0]    w_quo_next;
    logic            w_div_last;
    logic            w_cnt_wrap;

    // A new request is taken only in idle or run, and stop always wins.
    assign w_accept = start && !stop && (r_state == S_IDLE || r_state == S_RUN);
    assign w_in_bad = (bcd3 > 4'd9) || (bcd2 > 4'd9) || (bcd1 > 4'd9) || (bcd0 > 4'd9);

    // Digits are shifted out of the top nibble, most significant first.
    assign w_digit     = r_bcd[15:12];
    assign w_acc_next  = 14'(r_acc * 14'd10) + {10'd0, w_digit};
    assign w_conv_last = (r_idx == 2'd3);
    assign w_conv_bad  = r_bad || (w_acc_next == 14'd0);

    // Remainder stays below the divisor, so the difference fits in W bits.
    assign w_divisor  = W'(r_acc);
    assign w_shift    = {r_rem, r_quo[W-1]};
    assign w_ge       = (w_shift >= {1'b0, w_divisor});
    assign w_rem_next = w_ge ? (w_shift[W-1:0] - w_divisor) : w_shift[W-1:0];
    assign w_quo_next = {r_quo[W-2:0], w_ge};
    assign w_div_last = (r_dcnt == c_DIV_LAST);

    assign w_cnt_wrap = (r_cnt == (r_half - W'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        ready        = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (w_accept) begin
                    w_next_state = S_CONV;
                end
            end
            S_CONV: begin
                if (stop) begin
                    w_next_state = S_IDLE;
                end else if (w_conv_last) begin
                    w_next_state = w_conv_bad ? S_IDLE : S_DIV;
                end
            end
            S_DIV: begin
                if (stop) begin
                    w_next_state = S_IDLE;
                end else if (w_div_last) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_next_state = S_IDLE;
                end else if (w_accept) begin
                    w_next_state = S_CONV;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcd  <= '0;
            r_bad  <= 1'b0;
            r_idx  <= '0;
            r_acc  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_dcnt <= '0;
            r_half <= '0;
            r_cnt  <= '0;
            r_sq   <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_bcd <= {bcd3, bcd2, bcd1, bcd0};
                r_bad <= w_in_bad;
                r_idx <= '0;
                r_acc <= '0;
                r_err <= 1'b0;
                r_sq  <= 1'b0;
            end
            case (r_state)
                S_CONV: begin
                    r_acc  <= w_acc_next;
                    r_bcd  <= {r_bcd[11:0], 4'd0};
                    r_idx  <= r_idx + 2'd1;
                    r_rem  <= '0;
                    r_quo  <= c_DIVIDEND;
                    r_dcnt <= '0;
                    if (w_conv_last && w_conv_bad && !stop) begin
                        r_err <= 1'b1;
                    end
                end
                S_DIV: begin
                    r_rem  <= w_rem_next;
                    r_quo  <= w_quo_next;
                    r_dcnt <= r_dcnt + c_CW'(1);
                    if (w_div_last && !stop) begin
                        r_half <= (w_quo_next == '0) ? W'(1) : w_quo_next;
                        r_done <= 1'b1;
                        r_sq   <= 1'b1;
                        r_cnt  <= '0;
                    end
                end
                S_RUN: begin
                    if (!w_accept && !stop) begin
                        if (w_cnt_wrap) begin
                            r_sq  <= ~r_sq;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + W'(1);
                        end
                    end
                end
                default: ;
            endcase
            if (stop && r_state != S_IDLE) begin
                r_sq <= 1'b0;
            end
        end
    end

    assign sq_out    = r_sq;
    assign done_tick = r_done;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_low_freq_generator.sv
// ============================================================================
//  Module      : tb_low_freq_generator
//  Description : Directed self-checking bench; two instances (CLK_HZ 20000 and
//                1000, W=16) share stimulus so the half-period clamp is covered.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_low_freq_generator;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic [3:0] bcd3, bcd2, bcd1, bcd0;
    logic       sq_a, ready_a, done_a, err_a;
    logic       sq_b, ready_b, done_b, err_b;

    int n_vec = 0;
    int n_err = 0;

    low_freq_generator #(.CLK_HZ(20000), .W(16)) dut_a (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
        .sq_out(sq_a), .ready(ready_a), .done_tick(done_a), .err(err_a)
    );

    low_freq_generator #(.CLK_HZ(1000), .W(16)) dut_b (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
        .sq_out(sq_b), .ready(ready_b), .done_tick(done_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [3:0] d3, d2, d1, d0);
        bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0;
        start = 1'b1;
        tick();
        start = 1'b0;
        bcd3 = 4'hF; bcd2 = 4'hF; bcd1 = 4'hF; bcd0 = 4'hF;
    endtask

    task automatic wait_done(output int k, output logic saw_hi);
        k = 0;
        saw_hi = 1'b0;
        while (k < 200) begin
            tick();
            k++;
            if (done_a) break;
            saw_hi |= sq_a;
        end
    endtask

    task automatic measure(input logic level, output int n);
        n = 0;
        while (sq_a == level && n < 20010) begin
            n++;
            tick();
        end
    endtask

    task automatic count_done(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done_a || done_b) seen++;
        end
    endtask

    int   k, n, seen;
    logic saw;

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        bcd3 = 4'd0; bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd0;
        repeat (3) tick();
        check("rst_sq", int'(sq_a), 0);
        check("rst_ready", int'(ready_a), 1);
        check("rst_err", int'(err_a), 0);
        check("rst_done", int'(done_a), 0);
        reset = 1'b0;
        tick();

        // 1 Hz: half = 10000
        do_start(4'd0, 4'd0, 4'd0, 4'd1);
        wait_done(k, saw);
        check("lat_1hz", k, 20);
        check("sq_at_done", int'(sq_a), 1);
        measure(1'b1, n);
        check("hi_1hz", n, 10000);
        measure(1'b0, n);
        check("lo_1hz", n, 10000);

        // 1000 Hz restarted from run: half = 10
        do_start(4'd1, 4'd0, 4'd0, 4'd0);
        wait_done(k, saw);
        check("lat_1khz", k, 20);
        check("sq_off_recalc", int'(saw), 0);
        tick();
        check("done_one_cycle", int'(done_a), 0);
        check("hi_rest_1khz", int'(sq_a), 1);
        measure(1'b1, n);
        check("hi_first_1khz", n, 9);
        for (int p = 0; p < 5; p++) begin
            measure(1'b0, n);
            check($sformatf("lo_1khz_%0d", p), n, 10);
            measure(1'b1, n);
            check($sformatf("hi_1khz_%0d", p), n, 10);
        end

        // stop from run
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_sq", int'(sq_a), 0);
        check("stop_ready", int'(ready_a), 1);

        // 9999 Hz: quotient 1 (A) and 0 clamped to 1 (B)
        do_start(4'd9, 4'd9, 4'd9, 4'd9);
        wait_done(k, saw);
        check("lat_9999", k, 20);
        check("done_b_9999", int'(done_b), 1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("tog_a_%0d", i), int'(sq_a), (i % 2 == 0) ? 1 : 0);
            check($sformatf("tog_b_%0d", i), int'(sq_b), (i % 2 == 0) ? 1 : 0);
            tick();
        end

        // invalid requests
        do_start(4'd0, 4'd0, 4'd0, 4'd0);
        repeat (3) tick();
        check("zero_err_early", int'(err_a), 0);
        check("zero_busy", int'(ready_a), 0);
        tick();
        check("zero_err", int'(err_a), 1);
        check("zero_idle", int'(ready_a), 1);
        count_done(30, seen);
        check("zero_no_done", seen, 0);
        check("zero_err_hold", int'(err_a), 1);

        do_start(4'd0, 4'd0, 4'hA, 4'd1);
        repeat (4) tick();
        check("hex_err", int'(err_a), 1);
        check("hex_idle", int'(ready_a), 1);
        count_done(30, seen);
        check("hex_no_done", seen, 0);

        do_start(4'd1, 4'd0, 4'd0, 4'd0);
        check("err_cleared", int'(err_a), 0);
        wait_done(k, saw);
        check("lat_after_err", k, 20);

        // 500 Hz from run: half = 20
        repeat (7) tick();
        do_start(4'd0, 4'd5, 4'd0, 4'd0);
        wait_done(k, saw);
        check("lat_500", k, 20);
        check("sq_off_500", int'(saw), 0);
        measure(1'b1, n);
        check("hi_500", n, 20);
        measure(1'b0, n);
        check("lo_500", n, 20);

        // start and stop together: stop wins
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("ss_ready", int'(ready_a), 1);
        check("ss_sq", int'(sq_a), 0);
        count_done(30, seen);
        check("ss_no_done", seen, 0);

        // reset mid-div
        do_start(4'd1, 4'd0, 4'd0, 4'd0);
        repeat (8) tick();
        check("div_busy", int'(ready_a), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rdiv_ready", int'(ready_a), 1);
        check("rdiv_sq", int'(sq_a), 0);
        check("rdiv_done", int'(done_a), 0);
        count_done(30, seen);
        check("rdiv_no_done", seen, 0);

        // reset mid-run
        do_start(4'd1, 4'd0, 4'd0, 4'd0);
        wait_done(k, saw);
        check("lat_prerst", k, 20);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rrun_ready", int'(ready_a), 1);
        check("rrun_sq", int'(sq_a), 0);
        check("rrun_err", int'(err_a), 0);
        count_done(30, seen);
        check("rrun_no_done", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/low_freq_generator.md
Name: low_freq_generator

Overview:
Square-wave generator that produces an output at a frequency given as four BCD digits (1–9999 Hz). It converts the BCD frequency to binary, computes the half-period in clock cycles by sequential restoring division, then toggles the output from a half-period counter. It is the synthesis counterpart of the low-frequency measurement path and shares its BCD digit format, so a measured value can be regenerated directly. The block is self-contained and instantiates no submodules.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz; dividend is CLK_HZ/2 (integer, compile-time constant)
W, 27, width of the dividend, quotient and half-period counter; must satisfy 2^W > CLK_HZ/2

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to load bcd3..bcd0 and (re)start generation
stop  input  1  halts generation, returns to idle
bcd3  input  4  thousands digit of frequency in Hz
bcd2  input  4  hundreds digit
bcd1  input  4  tens digit
bcd0  input  4  units digit
sq_out  output  1  generated square wave
ready  output  1  high in idle (a new start is accepted in idle and run)
done_tick  output  1  one-cycle pulse when the computed waveform begins
err  output  1  level: last request invalid (digit >9 or frequency 0)

Behaviour:
- Reset values: state=idle, sq_out=0, ready=1, done_tick=0, err=0; all counters and registers cleared. Reset mid-computation or mid-run aborts immediately.
- States: idle, conv, div, run.
- idle: ready=1, sq_out=0. On start, capture all four digits, clear err, and go to conv.
- conv (4 cycles): acc <= acc*10 + digit, processed MSD first (bcd3, bcd2, bcd1, bcd0); acc is 14 bits.
  - At the end of conv, if any captured digit >9 or acc==0: set err=1 and return to idle. No done_tick.
  - Otherwise go to div.
- div (W cycles): restoring division, one quotient bit per cycle, MSB first.
  - Dividend is CLK_HZ/2; divisor is acc zero-extended to W bits. The remainder is discarded.
  - half = quotient, clamped to a minimum of 1.
- Entry to run, exactly 4+W cycles after the start cycle:
  - done_tick=1 for that single cycle.
  - sq_out=1 and the half-period counter cnt=0 in the same cycle.
- run:
  - cnt increments each cycle. When cnt==half-1: sq_out toggles and cnt resets to 0.
  - Result: high for half cycles, low for half cycles, period 2*half cycles.
- stop in conv, div or run: go to idle next cycle, sq_out=0. stop in idle is ignored.
- start in run: re-capture the digits and go to conv. sq_out is forced to 0 during the recomputation.
- start and stop asserted in the same cycle: stop wins.
- start in conv or div is ignored; the request in progress completes.
- Input digits are sampled only on the accepted start cycle; later changes have no effect.
- err holds until the next accepted start or reset.

Test Plan:
- Reset with CLK_HZ=20000, W=16 -> sq_out=0, ready=1, err=0. Digits 0,0,0,1 plus start -> done_tick exactly 20 cycles later; sq_out then high 10000 cycles and low 10000 cycles, repeating.
- Same parameters, digits 1,0,0,0 (1000 Hz) -> half=10; sq_out period 20 cycles. Check 5 full periods and a 50% duty cycle.
- Digits 9,9,9,9 with CLK_HZ=20000 -> quotient 1, half=1; sq_out toggles every cycle. Repeat with CLK_HZ=1000 -> quotient 0 clamped to 1, same behaviour.
- Digits 0,0,0,0 -> err=1 four cycles after start, no done_tick, back in idle. Digits 0,0,A,1 -> err=1 likewise. A following valid start clears err.
- While running at 1000 Hz: stop -> sq_out=0 and ready=1 next cycle. Start with 0,5,0,0 (500 Hz) from run -> sq_out=0 for 20 cycles, then done_tick and period 40. Start+stop together -> idle.
- Reset asserted mid-div and mid-run -> all outputs return to reset values on the next edge, and no done_tick is emitted.
